// File: rtl/spi_slave_responder.sv
// SPI mode-0 MSB-first slave responder: oversampled pins, rx valid/ready out,
// one-deep tx holding register returned on MISO.
module spi_slave_responder #(
  parameter int unsigned     DATA_W      = 8,
  parameter int unsigned     SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_FILL = 8'hFF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sclk_i,
  input  logic              cs_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              rx_overrun_o,
  output logic              tx_underrun_o,
  output logic [9:0]        byte_count_o,
  output logic              frame_done_o,
  output logic              frame_err_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam int unsigned BC_W  = 10;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0]  cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
  logic                    sclk_prev_q, sclk_prev_d;
  logic                    cs_prev_q, cs_prev_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-2:0]       rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]       tx_shift_q, tx_shift_d;
  logic                    oe_q, oe_d;
  logic [DATA_W-1:0]       rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    overrun_q, overrun_d;
  logic                    underrun_q, underrun_d;
  logic [BC_W-1:0]         byte_count_q, byte_count_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [DATA_W-1:0]       hold_q, hold_d;
  logic                    tx_ready_q, tx_ready_d;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic load;
  logic [DATA_W-1:0] load_byte;

  // Edge detection on the synchronized samples.
  always_comb begin
    sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    cs_s      = cs_sync_q[SYNC_STAGES-1];
    mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    sclk_rise = sclk_s & ~sclk_prev_q;
    sclk_fall = ~sclk_s & sclk_prev_q;
    cs_rise   = cs_s & ~cs_prev_q;
    cs_fall   = ~cs_s & cs_prev_q;
    load_byte = tx_ready_q ? IDLE_FILL : hold_q;
  end

  // Next-state and datapath; CS_N rise wins over any SCLK edge.
  always_comb begin
    sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
    cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
    mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
    sclk_prev_d  = sclk_s;
    cs_prev_d    = cs_s;
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    tx_shift_d   = tx_shift_q;
    oe_d         = oe_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    overrun_d    = overrun_q;
    underrun_d   = underrun_q;
    byte_count_d = byte_count_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    hold_d       = hold_q;
    tx_ready_d   = tx_ready_q;
    load         = 1'b0;

    if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        oe_d = 1'b0;
        if (cs_fall) begin
          bit_cnt_d    = '0;
          byte_count_d = '0;
          overrun_d    = 1'b0;
          underrun_d   = 1'b0;
          load         = 1'b1;
          oe_d         = 1'b1;
          state_d      = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d   = IDLE;
          oe_d      = 1'b0;
          done_d    = 1'b1;
          err_d     = (bit_cnt_q != '0);
          bit_cnt_d = '0;
        end else if (sclk_rise) begin
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            rx_data_d  = {rx_shift_q, mosi_s};
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rx_ready_i) overrun_d = 1'b1;
            if (byte_count_q != '1) byte_count_d = byte_count_q + BC_W'(1);
            bit_cnt_d  = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
          rx_shift_d = {rx_shift_q[DATA_W-3:0], mosi_s};
        end else if (sclk_fall) begin
          if (bit_cnt_q == '0) load = 1'b1;
          else tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      tx_shift_d = load_byte;
      if (tx_ready_q) underrun_d = 1'b1;
      else tx_ready_d = 1'b1;
    end

    if (tx_valid_i && tx_ready_q) begin
      hold_d     = tx_data_i;
      tx_ready_d = 1'b0;
    end
  end

  // State registers with idle-level synchronizer reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      sclk_sync_q  <= '0;
      cs_sync_q    <= '1;
      mosi_sync_q  <= '0;
      sclk_prev_q  <= 1'b0;
      cs_prev_q    <= 1'b1;
      bit_cnt_q    <= '0;
      rx_shift_q   <= '0;
      tx_shift_q   <= IDLE_FILL;
      oe_q         <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
      byte_count_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      hold_q       <= '0;
      tx_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      sclk_sync_q  <= sclk_sync_d;
      cs_sync_q    <= cs_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      sclk_prev_q  <= sclk_prev_d;
      cs_prev_q    <= cs_prev_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      tx_shift_q   <= tx_shift_d;
      oe_q         <= oe_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      overrun_q    <= overrun_d;
      underrun_q   <= underrun_d;
      byte_count_q <= byte_count_d;
      done_q       <= done_d;
      err_q        <= err_d;
      hold_q       <= hold_d;
      tx_ready_q   <= tx_ready_d;
    end
  end

  assign miso_o        = tx_shift_q[DATA_W-1];
  assign miso_oe_o     = oe_q;
  assign tx_ready_o    = tx_ready_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign rx_overrun_o  = overrun_q;
  assign tx_underrun_o = underrun_q;
  assign byte_count_o  = byte_count_q;
  assign frame_done_o  = done_q;
  assign frame_err_o   = err_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Self-checking bench for spi_slave_responder acting as an SPI mode-0 master.
module tb_spi_slave_responder;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso_o, miso_oe_o;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready = 1'b1;
  logic       rx_overrun_o, tx_underrun_o;
  logic [9:0] byte_count_o;
  logic       frame_done_o, frame_err_o;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int rxv_cnt = 0;
  logic rxv_prev = 1'b0;
  logic [7:0] exp_rx_q[$];
  logic [7:0] got_rx_q[$];

  spi_slave_responder dut (
    .clk_i(clk), .rst_ni(rst_n), .sclk_i(sclk), .cs_n_i(cs_n), .mosi_i(mosi),
    .miso_o(miso_o), .miso_oe_o(miso_oe_o), .tx_data_i(tx_data),
    .tx_valid_i(tx_valid), .tx_ready_o(tx_ready_o), .rx_data_o(rx_data_o),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready), .rx_overrun_o(rx_overrun_o),
    .tx_underrun_o(tx_underrun_o), .byte_count_o(byte_count_o),
    .frame_done_o(frame_done_o), .frame_err_o(frame_err_o)
  );

  always #5 clk = ~clk;

  // Collect received bytes and pulse counts away from the active edge.
  always @(negedge clk) begin
    if (rx_valid_o && !rxv_prev) begin
      got_rx_q.push_back(rx_data_o);
      rxv_cnt++;
    end
    rxv_prev = rx_valid_o;
    if (frame_done_o) done_cnt++;
    if (frame_err_o) err_cnt++;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_write(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
    cycles(HALF);
  endtask

  task automatic cs_high();
    @(negedge clk);
    cs_n = 1'b1;
    cycles(HALF);
  endtask

  task automatic bit_xfer(input logic b, output logic m);
    mosi = b;
    cycles(HALF);
    sclk = 1'b1;
    m = miso_o;
    cycles(HALF);
    sclk = 1'b0;
  endtask

  // Full byte: the master compares what it clocked in on MISO.
  task automatic spi_byte(input logic [7:0] b, input logic [7:0] exp_m, input string name);
    logic [7:0] m;
    logic bt;
    m = '0;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(b[i], bt);
      m = {m[6:0], bt};
    end
    total++;
    if (m !== exp_m) begin
      bad++;
      $display("FAIL %s_miso: got %h required %h", name, m, exp_m);
    end
  endtask

  task automatic test_reset();
    cycles(2);
    total++; if (miso_o !== 1'b1) begin bad++; $display("FAIL reset_miso: got %b required 1", miso_o); end
    total++; if (miso_oe_o !== 1'b0) begin bad++; $display("FAIL reset_oe: got %b required 0", miso_oe_o); end
    total++; if (tx_ready_o !== 1'b1) begin bad++; $display("FAIL reset_tx_ready: got %b required 1", tx_ready_o); end
    total++; if ({rx_valid_o, rx_overrun_o, tx_underrun_o, frame_done_o, frame_err_o} !== 5'b0)
      begin bad++; $display("FAIL reset_flags: got %b required 00000",
        {rx_valid_o, rx_overrun_o, tx_underrun_o, frame_done_o, frame_err_o}); end
    total++; if ({rx_data_o, byte_count_o} !== 18'h0) begin bad++;
      $display("FAIL reset_data: got %h/%0d required 0/0", rx_data_o, byte_count_o); end
    rst_n = 1'b1;
    cycles(4);
  endtask

  task automatic test_single();
    int d0;
    logic [7:0] e, g;
    d0 = done_cnt;
    tx_write(8'hA5);
    total++; if (tx_ready_o !== 1'b0) begin bad++; $display("FAIL single_ready_wr: got %b required 0", tx_ready_o); end
    cs_low();
    total++; if (miso_oe_o !== 1'b1) begin bad++; $display("FAIL single_oe: got %b required 1", miso_oe_o); end
    total++; if (tx_ready_o !== 1'b1) begin bad++; $display("FAIL single_ready_ld: got %b required 1", tx_ready_o); end
    exp_rx_q.push_back(8'h3C);
    spi_byte(8'h3C, 8'hA5, "single");
    cycles(HALF);
    cs_high();
    total++; if (byte_count_o !== 10'd1) begin bad++; $display("FAIL single_count: got %0d required 1", byte_count_o); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL single_done: got %0d pulses required 1", done_cnt - d0); end
    total++; if (miso_oe_o !== 1'b0) begin bad++; $display("FAIL single_oe_off: got %b required 0", miso_oe_o); end
    // The trailing 8th SCLK fall loaded the next byte from an empty holding register.
    total++; if (tx_underrun_o !== 1'b1) begin bad++; $display("FAIL single_underrun: got %b required 1", tx_underrun_o); end
    while (exp_rx_q.size() != 0) begin
      e = exp_rx_q.pop_front();
      total++;
      if (got_rx_q.size() == 0) begin bad++; $display("FAIL single_rx: got none required %h", e); end
      else begin g = got_rx_q.pop_front();
        if (g !== e) begin bad++; $display("FAIL single_rx: got %h required %h", g, e); end end
    end
  endtask

  task automatic test_underrun();
    int v0;
    logic [7:0] e, g;
    v0 = rxv_cnt;
    rx_ready = 1'b1;
    cs_low();
    total++; if (tx_underrun_o !== 1'b1) begin bad++; $display("FAIL under_first: got %b required 1", tx_underrun_o); end
    for (int i = 1; i <= 3; i++) begin
      exp_rx_q.push_back(8'(i));
      spi_byte(8'(i), 8'hFF, "under");
    end
    cycles(HALF);
    cs_high();
    total++; if (byte_count_o !== 10'd3) begin bad++; $display("FAIL under_count: got %0d required 3", byte_count_o); end
    total++; if (rxv_cnt - v0 != 3) begin bad++; $display("FAIL under_rxv: got %0d required 3", rxv_cnt - v0); end
    while (exp_rx_q.size() != 0) begin
      e = exp_rx_q.pop_front();
      total++;
      if (got_rx_q.size() == 0) begin bad++; $display("FAIL under_rx: got none required %h", e); end
      else begin g = got_rx_q.pop_front();
        if (g !== e) begin bad++; $display("FAIL under_rx: got %h required %h", g, e); end end
    end
  endtask

  task automatic test_overrun();
    logic [7:0] g;
    rx_ready = 1'b0;
    cs_low();
    spi_byte(8'h11, 8'hFF, "ovr1");
    cycles(HALF);
    total++; if ({rx_valid_o, rx_data_o, rx_overrun_o} !== {1'b1, 8'h11, 1'b0}) begin bad++;
      $display("FAIL ovr_first: got v=%b d=%h o=%b required v=1 d=11 o=0", rx_valid_o, rx_data_o, rx_overrun_o); end
    spi_byte(8'h22, 8'hFF, "ovr2");
    cycles(HALF);
    total++; if (rx_data_o !== 8'h22) begin bad++; $display("FAIL ovr_data: got %h required 22", rx_data_o); end
    total++; if (rx_overrun_o !== 1'b1) begin bad++; $display("FAIL ovr_flag: got %b required 1", rx_overrun_o); end
    cs_high();
    total++; if (got_rx_q.size() != 1) begin bad++; $display("FAIL ovr_rises: got %0d required 1", got_rx_q.size()); end
    else begin g = got_rx_q.pop_front();
      if (g !== 8'h11) begin bad++; $display("FAIL ovr_rises: got %h required 11", g); end end
    tx_write(8'h77);
    rx_ready = 1'b1;
    cs_low();
    total++; if ({rx_overrun_o, tx_underrun_o} !== 2'b00) begin bad++;
      $display("FAIL ovr_clear: got %b required 00", {rx_overrun_o, tx_underrun_o}); end
    cs_high();
  endtask

  task automatic test_frame_err();
    int e0, d0;
    logic bt;
    logic [7:0] pat, e, g;
    pat = 8'hAA;
    e0 = err_cnt;
    d0 = done_cnt;
    cs_low();
    exp_rx_q.push_back(8'h55);
    spi_byte(8'h55, 8'hFF, "ferr");
    for (int i = 7; i >= 3; i--) bit_xfer(pat[i], bt);
    cycles(HALF);
    cs_high();
    total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL ferr_pulse: got %0d required 1", err_cnt - e0); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL ferr_done: got %0d required 1", done_cnt - d0); end
    total++; if (rx_data_o !== 8'h55) begin bad++; $display("FAIL ferr_data: got %h required 55", rx_data_o); end
    cs_low();
    exp_rx_q.push_back(8'h7E);
    spi_byte(8'h7E, 8'hFF, "ferr_next");
    cycles(HALF);
    total++; if (byte_count_o !== 10'd1) begin bad++; $display("FAIL ferr_next_count: got %0d required 1", byte_count_o); end
    cs_high();
    total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL ferr_clean: got %0d required 1", err_cnt - e0); end
    while (exp_rx_q.size() != 0) begin
      e = exp_rx_q.pop_front();
      total++;
      if (got_rx_q.size() == 0) begin bad++; $display("FAIL ferr_rx: got none required %h", e); end
      else begin g = got_rx_q.pop_front();
        if (g !== e) begin bad++; $display("FAIL ferr_rx: got %h required %h", g, e); end end
    end
  endtask

  task automatic test_reset_mid();
    int v0;
    logic bt;
    tx_write(8'h99);
    cs_low();
    for (int i = 0; i < 3; i++) bit_xfer(1'b1, bt);
    tx_write(8'h33);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (miso_oe_o !== 1'b0) begin bad++; $display("FAIL rstmid_oe: got %b required 0", miso_oe_o); end
    total++; if (tx_ready_o !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %b required 1", tx_ready_o); end
    total++; if ({miso_o, byte_count_o} !== {1'b1, 10'd0}) begin bad++;
      $display("FAIL rstmid_vals: got miso=%b cnt=%0d required 1/0", miso_o, byte_count_o); end
    cs_n = 1'b1;
    sclk = 1'b0;
    cycles(4);
    v0 = rxv_cnt;
    rst_n = 1'b1;
    cycles(4 * HALF);
    total++; if (rx_valid_o !== 1'b0 || rxv_cnt != v0) begin bad++;
      $display("FAIL rstmid_rxv: got v=%b rises=%0d required 0/0", rx_valid_o, rxv_cnt - v0); end
  endtask

  task automatic test_back_to_back();
    logic bt;
    logic [7:0] m0, b0, e, g;
    b0 = 8'h96;
    m0 = '0;
    rx_ready = 1'b1;
    tx_write(8'h5A);
    cs_low();
    exp_rx_q.push_back(8'h96);
    for (int i = 7; i >= 4; i--) begin bit_xfer(b0[i], bt); m0 = {m0[6:0], bt}; end
    tx_write(8'hC3);
    total++; if (tx_ready_o !== 1'b0) begin bad++; $display("FAIL b2b_ready_wr: got %b required 0", tx_ready_o); end
    for (int i = 3; i >= 1; i--) begin bit_xfer(b0[i], bt); m0 = {m0[6:0], bt}; end
    mosi = b0[0];
    cycles(HALF);
    sclk = 1'b1;
    m0 = {m0[6:0], miso_o};
    cycles(HALF);
    total++; if (tx_ready_o !== 1'b0) begin bad++; $display("FAIL b2b_ready_hold: got %b required 0", tx_ready_o); end
    sclk = 1'b0;
    cycles(HALF);
    total++; if (tx_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready_ld: got %b required 1", tx_ready_o); end
    total++; if (m0 !== 8'h5A) begin bad++; $display("FAIL b2b_miso0: got %h required 5A", m0); end
    exp_rx_q.push_back(8'h69);
    spi_byte(8'h69, 8'hC3, "b2b1");
    cycles(HALF);
    cs_high();
    total++; if (byte_count_o !== 10'd2) begin bad++; $display("FAIL b2b_count: got %0d required 2", byte_count_o); end
    while (exp_rx_q.size() != 0) begin
      e = exp_rx_q.pop_front();
      total++;
      if (got_rx_q.size() == 0) begin bad++; $display("FAIL b2b_rx: got none required %h", e); end
      else begin g = got_rx_q.pop_front();
        if (g !== e) begin bad++; $display("FAIL b2b_rx: got %h required %h", g, e); end end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_underrun();
    test_overrun();
    test_frame_err();
    test_reset_mid();
    test_back_to_back();
    total++;
    if (got_rx_q.size() != 0) begin bad++; $display("FAIL stray_rx: got %0d extra bytes required 0", got_rx_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
- SPI mode-0 (CPOL=0, CPHA=0), MSB-first, 8-bit-per-byte responder; the slave end of the link driven by the team's SPI master controller.
- Oversamples SCLK, CS_N and MOSI in the clk_i domain.
- Shifts received bytes out on a valid/ready interface and returns bytes from a one-deep transmit holding register on MISO.
- Sits between the SPI pins and the register/memory write path used by the peripheral side.

Parameters:
- DATA_W, 8, bits per SPI byte.
- SYNC_STAGES, 2, synchronizer flops on sclk_i, cs_n_i and mosi_i (minimum 2).
- IDLE_FILL, 8'hFF, byte shifted out when no transmit byte is pending (underrun).

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- sclk_i  input  1  SPI serial clock from master
- cs_n_i  input  1  chip select, active low
- mosi_i  input  1  master out, slave in
- miso_o  output  1  slave out, master in
- miso_oe_o  output  1  MISO output enable; high only while frame active
- tx_data_i  input  DATA_W  next byte to return
- tx_valid_i  input  1  tx_data_i valid
- tx_ready_o  output  1  holding register empty
- rx_data_o  output  DATA_W  last received byte
- rx_valid_o  output  1  rx_data_o valid; held until accepted
- rx_ready_i  input  1  consumer accepts rx_data_o
- rx_overrun_o  output  1  sticky: byte overwritten while rx_valid_o high
- tx_underrun_o  output  1  sticky: IDLE_FILL was sent
- byte_count_o  output  10  bytes completed in current frame, saturating at 1023
- frame_done_o  output  1  one-cycle pulse at CS_N deassert
- frame_err_o  output  1  one-cycle pulse when CS_N deasserts mid-byte

Behaviour:
- Reset (rst_ni low, asynchronous): all outputs 0 except tx_ready_o=1 and miso_o=IDLE_FILL[DATA_W-1]. Synchronizer chains reset to the idle levels sclk=0, cs_n=1, mosi=0. State returns to IDLE and any frame in progress is discarded.
- Synchronization: rise and fall events come from the last two synchronized samples. All timing below is counted from the synchronized event.
- Electrical requirement: SCLK high and low each ≥ SYNC_STAGES+2 clk_i cycles. CS_N setup to the first SCLK rise ≥ SYNC_STAGES+2 cycles.
- Holding register: tx_valid_i && tx_ready_o writes it and clears tx_ready_o on the next cycle. It is consumed at each byte load, which sets tx_ready_o.
- FSM IDLE:
  - miso_oe_o=0.
  - On CS_N fall: clear bit_cnt, byte_count_o and both sticky flags.
  - Load the tx shift register from the holding register, or from IDLE_FILL if it is empty (this sets tx_underrun_o).
  - Drive miso_o=MSB and miso_oe_o=1 in the same cycle as the event.
  - Go to SHIFT.
- FSM SHIFT, SCLK rise:
  - rx_shift <= {rx_shift[DATA_W-2:0], mosi}; bit_cnt++.
  - When bit_cnt reaches DATA_W, on the same edge: rx_data_o <= the completed byte, rx_valid_o=1, byte_count_o++ (saturating), bit_cnt <= 0.
  - If rx_valid_o was already high and rx_ready_i is low that cycle, set rx_overrun_o. The new byte overwrites rx_data_o.
- FSM SHIFT, SCLK fall:
  - If bit_cnt==0, a byte boundary: load the next tx byte (holding register or IDLE_FILL, as in IDLE) and drive its MSB.
  - Otherwise shift tx left and drive the next bit.
- rx handshake: rx_valid_o clears the cycle after rx_valid_o && rx_ready_i. A simultaneous new byte keeps rx_valid_o=1 with the new data and no overrun.
- FSM SHIFT, CS_N rise:
  - Return to IDLE; miso_oe_o=0; pulse frame_done_o.
  - If bit_cnt≠0, discard the partial byte and also pulse frame_err_o; rx_data_o and rx_valid_o are unchanged.
  - byte_count_o holds its value until the next CS_N fall.
- Event priority: a CS_N rise in the same cycle as an SCLK edge takes priority; the edge is ignored.
- The holding register and tx_ready_o persist across frames.

Test Plan:
- Reset, then one frame: preload tx 8'hA5; master sends 8'h3C. Required: rx_data_o=8'h3C with rx_valid_o; MISO bits 1,0,1,0,0,1,0,1; byte_count_o=1; frame_done_o pulse; tx_ready_o=1.
- Three-byte frame, no tx preload, rx_ready_i tied high. Master sends 8'h01,8'h02,8'h03. Required: MISO returns 8'hFF ×3; tx_underrun_o=1; byte_count_o=3; three rx_valid_o assertions.
- rx_ready_i held low, master sends 8'h11 then 8'h22. Required: rx_data_o=8'h22; rx_overrun_o=1 after the second byte; both flags clear at the next CS_N fall.
- CS_N deasserted after 5 SCLK rises of the second byte (first byte 8'h55). Required: frame_err_o pulse; rx_data_o stays 8'h55; next frame starts with bit_cnt=0.
- Assert rst_ni low mid-byte with tx pending. Required: immediate return to reset values; miso_oe_o=0; tx_ready_o=1; no rx_valid_o after release.
- Back-to-back tx: write 8'hC3 during byte 0 of a 2-byte frame (byte 0 = 8'h5A). Required: MISO returns 8'h5A then 8'hC3; tx_ready_o falls on the write and rises at the load on the 8th SCLK fall.
